// File: rtl/click_pkg.sv
// click_pkg: shared types and default constants for the button click decoder.
//   click_state_t          - FSM state encoding
//   CLICK_*_DEF            - default timing constants in 400 Hz ticks
//   click_max3()           - helper used to size the shared counter
package click_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD1 = 3'd1,
        WAIT2 = 3'd2,
        HELD2 = 3'd3,
        LONG  = 3'd4
    } click_state_t;

    localparam int CLICK_LONG_TICKS_DEF   = 400;
    localparam int CLICK_DOUBLE_WIN_DEF   = 120;
    localparam int CLICK_REPEAT_TICKS_DEF = 80;

    function automatic int click_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// tick_counter: up-counter with synchronous clear, count enable and a
// terminal-count compare. On enable at terminal count it wraps to zero.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   clr           - synchronous clear (priority over en)
//   en            - count enable
//   tc_val [W-1:0]- terminal count value
//   cnt    [W-1:0]- current count
//   tc            - cnt == tc_val
module tick_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == tc_val);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/button_click_decoder.sv
// button_click_decoder: classifies debounced button presses into single
// click, double click or long press, one registered one-cycle pulse each.
// Optional macro CLICK_REPEAT_EN enables auto-repeat pulses while a long
// press is held; without it repeat_pulse is constant 0.
// Ports:
//   clk           - 400 Hz slow clock (shared with the debouncer)
//   reset         - asynchronous active-low reset
//   press         - one-cycle debounced press pulse
//   level         - debounced button level, 1 = held
//   single_click  - one-cycle pulse, completed single click
//   double_click  - one-cycle pulse, completed double click
//   long_press    - one-cycle pulse when the hold reaches LONG_TICKS
//   repeat_pulse  - auto-repeat pulse while held after a long press
//   busy          - 1 whenever the FSM is not idle
//
// state | meaning
// IDLE  | waiting for a press
// HELD1 | first press held, timing toward long press
// WAIT2 | released, timing the double-click window
// HELD2 | second press held, double click on release
// LONG  | long press reported, waiting for release
module button_click_decoder
    import click_pkg::*;
#(
    parameter int LONG_TICKS   = CLICK_LONG_TICKS_DEF,
    parameter int DOUBLE_WIN   = CLICK_DOUBLE_WIN_DEF,
    parameter int REPEAT_TICKS = CLICK_REPEAT_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic press,
    input  logic level,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    localparam int CNT_MAX = click_max3(LONG_TICKS, DOUBLE_WIN, REPEAT_TICKS);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    click_state_t state_q, state_d;
    logic single_q, single_d;
    logic double_q, double_d;
    logic long_q,   long_d;
    logic rep_q,    rep_d;
    logic busy_q,   busy_d;

    logic             cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0] cnt, tc_val;

    tick_counter #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc_val (tc_val),
        .cnt    (cnt),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_en   = 1'b0;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        rep_d    = 1'b0;
        tc_val   = CNT_W'(REPEAT_TICKS - 1);

        case (state_q)
            IDLE: begin
                if (press) state_d = HELD1;
            end
            HELD1: begin
                tc_val = CNT_W'(LONG_TICKS - 1);
                // release is checked first so it beats the long-press threshold
                if (!level) begin
                    state_d = WAIT2;
                end else if (cnt_tc) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            WAIT2: begin
                tc_val = CNT_W'(DOUBLE_WIN - 1);
                // a press on the last window cycle still counts as a double click
                if (press) begin
                    state_d = HELD2;
                end else if (cnt_tc) begin
                    single_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HELD2: begin
                if (!level) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            LONG: begin
                if (!level) begin
                    state_d = IDLE;
                end else begin
`ifdef CLICK_REPEAT_EN
                    cnt_en = 1'b1;
                    rep_d  = cnt_tc;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_clr = (state_d != state_q);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            rep_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
            rep_q    <= rep_d;
            busy_q   <= busy_d;
        end
    end

    // the counter never runs past the largest terminal count
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (cnt < CNT_W'(CNT_MAX));
        end
    end

    assign single_click = single_q;
    assign double_click = double_q;
    assign long_press   = long_q;
    assign repeat_pulse = rep_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_button_click_decoder.sv
module tb_button_click_decoder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic press = 1'b0;
    logic level = 1'b0;
    logic single_click, double_click, long_press, repeat_pulse, busy;

    button_click_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .press        (press),
        .level        (level),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] K_SINGLE = 4'b1000;
    localparam logic [3:0] K_DOUBLE = 4'b0100;
    localparam logic [3:0] K_LONG   = 4'b0010;
    localparam logic [3:0] K_REP    = 4'b0001;

    typedef struct {
        int         at;
        logic [3:0] kind;
    } ev_t;

    ev_t exp_q[$];
    int  edge_cnt = 0;
    int  n_checks = 0;
    int  n_fail   = 0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    // scoreboard: every pulse seen on an output must match the next expected event
    logic [3:0] mon_obs;
    ev_t        mon_ev;
    always @(negedge clk) begin
        mon_obs = {single_click, double_click, long_press, repeat_pulse};
        if (mon_obs != 4'b0000) begin
            chk("one_hot_pulse", int'($countones(mon_obs[3:1]) <= 1), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", int'(mon_obs), 0);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("pulse_kind", int'(mon_obs), int'(mon_ev.kind));
                chk("pulse_edge", edge_cnt - 1, mon_ev.at);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int at, input logic [3:0] kind);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    // press at p1, released at r1; optional second press p2 released at r2 (p2 < 0: none)
    task automatic gesture(input int p1, input int r1, input int p2, input int r2, input int total);
        for (int c = 0; c < total; c++) begin
            press = (c == p1) || (p2 >= 0 && c == p2);
            level = (c >= p1 && c < r1) || (p2 >= 0 && c >= p2 && c < r2);
            tick();
            if (c == p1) chk("busy_after_press", busy, 1);
        end
        press = 1'b0;
        level = 1'b0;
    endtask

    task automatic end_checks(input string tag);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_busy_idle"}, busy, 0);
        exp_q.delete();
    endtask

    int t0;

    initial begin
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_outputs", int'({single_click, double_click, long_press, repeat_pulse}), 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (2) tick();

        // single click: release at 50
        t0 = edge_cnt;
        expect_ev(t0 + 170, K_SINGLE);
        gesture(0, 50, -1, -1, 200);
        end_checks("single");

        // double click
        t0 = edge_cnt;
        expect_ev(t0 + 130, K_DOUBLE);
        gesture(0, 40, 100, 130, 150);
        end_checks("double");

        // long press held to 600
        t0 = edge_cnt;
        expect_ev(t0 + 400, K_LONG);
`ifdef CLICK_REPEAT_EN
        expect_ev(t0 + 480, K_REP);
        expect_ev(t0 + 560, K_REP);
`endif
        gesture(0, 600, -1, -1, 620);
        end_checks("long");

        // release on the long-press threshold cycle
        t0 = edge_cnt;
        expect_ev(t0 + 520, K_SINGLE);
        gesture(0, 400, -1, -1, 560);
        end_checks("release_at_long");

        // second press on the last cycle of the double-click window
        t0 = edge_cnt;
        expect_ev(t0 + 180, K_DOUBLE);
        gesture(0, 40, 160, 180, 200);
        end_checks("press_at_expiry");

        // reset in WAIT2 at cycle 60
        gesture(0, 40, -1, -1, 60);
        chk("wait2_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("midrst_outputs", int'({single_click, double_click, long_press, repeat_pulse}), 0);
        chk("midrst_busy", busy, 0);
        repeat (3) tick();
        level = 1'b1;
        reset = 1'b1;
        repeat (200) tick();
        chk("held_no_press_busy", busy, 0);
        level = 1'b0;
        repeat (5) tick();
        end_checks("reset_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
